// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM states and dummy-cycle count shared by the flash responder
package spi_flash_pkg;
   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;
   localparam logic [7:0] OP_RDID      = 8'h9F;
   localparam int         DUMMY_BITS   = 8;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_ID,
      ST_IGNORE
   } state_t;
endpackage

// File: rtl/spi_flash_sync.sv
// spi_flash_sync: brings the async SPI pins into sys_clk and detects spi_clk edges
module spi_flash_sync (
   input  logic sys_clk,
   input  logic sys_reset,
   input  logic spi_cs_n,
   input  logic spi_clk,
   input  logic spi_mosi,
   output logic cs_n_s,
   output logic mosi_s,
   output logic rise,
   output logic fall
);
   logic [1:0] cs_q, cs_d;
   logic [2:0] clk_q, clk_d;
   logic [1:0] mosi_q, mosi_d;
   // two synchronizer stages per pin, plus a third stage on spi_clk for edge detection
   always_comb begin
      cs_d   = {cs_q[0], spi_cs_n};
      clk_d  = {clk_q[1:0], spi_clk};
      mosi_d = {mosi_q[0], spi_mosi};
   end
   // chip select resets deasserted so the responder cannot start a transfer out of reset
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         cs_q   <= 2'b11;
         clk_q  <= '0;
         mosi_q <= '0;
      end else begin
         cs_q   <= cs_d;
         clk_q  <= clk_d;
         mosi_q <= mosi_d;
      end
   end
   assign cs_n_s = cs_q[1];
   assign mosi_s = mosi_q[1];
   assign rise   = clk_q[1] & ~clk_q[2];
   assign fall   = ~clk_q[1] & clk_q[2];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 SPI flash emulator serving READ, FAST READ and JEDEC ID from a byte memory
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int          ADDR_W   = 16,
   parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   input  logic              spi_cs_n,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              cmd_err
);
   logic cs_n_s, mosi_s, rise, fall;
   spi_flash_sync u_sync (
      .sys_clk  (sys_clk),
      .sys_reset(sys_reset),
      .spi_cs_n (spi_cs_n),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .cs_n_s   (cs_n_s),
      .mosi_s   (mosi_s),
      .rise     (rise),
      .fall     (fall)
   );
   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [ADDR_W-2:0] shift_q, shift_d;
   logic              fast_q, fast_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        hold_q, hold_d;
   logic              first_q, first_d;
   logic              reload_q, reload_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        id_idx_q, id_idx_d;
   logic              miso_q, miso_d;
   logic              oe_q, oe_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              busy_q, busy_d;
   logic              cmd_err_q, cmd_err_d;
   logic [7:0]        op, tx_src;
   logic [ADDR_W-1:0] addr_in;
   logic [1:0]        id_nxt;
   function automatic logic [7:0] id_byte(input logic [1:0] i);
      return i == 2'd0 ? JEDEC_ID[23:16] : i == 2'd1 ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
   endfunction
   // next-state logic: command decode, address capture, memory prefetch and MISO serialisation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      fast_d     = fast_q;
      tx_d       = tx_q;
      hold_d     = hold_q;
      first_d    = first_q;
      reload_d   = reload_q;
      rvalid_d   = mem_req_q;
      id_idx_d   = id_idx_q;
      miso_d     = miso_q;
      mem_req_d  = 1'b0;
      mem_addr_d = mem_addr_q;
      cmd_err_d  = 1'b0;
      op         = {shift_q[6:0], mosi_s};
      addr_in    = {shift_q, mosi_s};
      tx_src     = reload_q ? hold_q : tx_q;
      id_nxt     = id_idx_q == 2'd2 ? 2'd0 : id_idx_q + 2'd1;
      if (rvalid_q) begin
         if (first_q) begin
            tx_d    = mem_rdata;
            first_d = 1'b0;
         end else begin
            hold_d = mem_rdata;
         end
      end
      if (cs_n_s) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         shift_d  = '0;
         miso_d   = 1'b0;
         first_d  = 1'b0;
         reload_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_CMD;
               cnt_d   = '0;
            end
            ST_CMD: if (rise) begin
               shift_d = {shift_q[ADDR_W-3:0], mosi_s};
               cnt_d   = cnt_q == 5'd7 ? 5'd0 : cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  if (op == OP_READ || op == OP_FAST_READ) begin
                     state_d = ST_ADDR;
                     fast_d  = op == OP_FAST_READ;
                  end else if (op == OP_RDID) begin
                     state_d  = ST_ID;
                     tx_d     = id_byte(2'd0);
                     id_idx_d = 2'd0;
                     reload_d = 1'b0;
                  end else begin
                     state_d   = ST_IGNORE;
                     cmd_err_d = 1'b1;
                  end
               end
            end
            ST_ADDR: if (rise) begin
               shift_d = {shift_q[ADDR_W-3:0], mosi_s};
               cnt_d   = cnt_q == 5'd23 ? 5'd0 : cnt_q + 5'd1;
               if (cnt_q == 5'd23) begin
                  mem_addr_d = addr_in;
                  state_d    = fast_q ? ST_DUMMY : ST_DATA;
                  mem_req_d  = ~fast_q;
                  first_d    = ~fast_q;
                  reload_d   = 1'b0;
               end
            end
            ST_DUMMY: if (rise) begin
               cnt_d = cnt_q == 5'(DUMMY_BITS - 1) ? 5'd0 : cnt_q + 5'd1;
               if (cnt_q == 5'(DUMMY_BITS - 1)) begin
                  state_d   = ST_DATA;
                  mem_req_d = 1'b1;
                  first_d   = 1'b1;
                  reload_d  = 1'b0;
               end
            end
            ST_DATA, ST_ID: if (fall) begin
               miso_d   = tx_src[7];
               tx_d     = {tx_src[6:0], 1'b0};
               reload_d = cnt_q == 5'd7;
               cnt_d    = cnt_q == 5'd7 ? 5'd0 : cnt_q + 5'd1;
               if (cnt_q == 5'd7 && state_q == ST_DATA) begin
                  mem_req_d  = 1'b1;
                  mem_addr_d = mem_addr_q + ADDR_W'(1);
               end
               if (cnt_q == 5'd7 && state_q == ST_ID) begin
                  hold_d   = id_byte(id_nxt);
                  id_idx_d = id_nxt;
               end
            end
            default: ;
         endcase
      end
      oe_d   = state_d == ST_DATA || state_d == ST_ID;
      busy_d = state_d != ST_IDLE;
   end
   // single register bank for FSM state, datapath and all registered outputs
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         fast_q     <= 1'b0;
         tx_q       <= '0;
         hold_q     <= '0;
         first_q    <= 1'b0;
         reload_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         id_idx_q   <= '0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         fast_q     <= fast_d;
         tx_q       <= tx_d;
         hold_q     <= hold_d;
         first_q    <= first_d;
         reload_q   <= reload_d;
         rvalid_q   <= rvalid_d;
         id_idx_q   <= id_idx_d;
         miso_q     <= miso_d;
         oe_q       <= oe_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
         cmd_err_q  <= cmd_err_d;
      end
   end
   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign busy        = busy_q;
   assign cmd_err     = cmd_err_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: SPI master driving the responder against a byte-array flash model
module tb_spi_flash_responder;
   logic        sys_clk = 1'b0;
   logic        sys_reset = 1'b1;
   logic        spi_cs_n = 1'b1;
   logic        spi_clk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe, mem_req, busy, cmd_err;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic [7:0]  mem [0:65535];
   logic [7:0]  got[$];
   logic        req_ok = 1'b0;
   logic        no_oe = 1'b1;
   logic [15:0] exp_addr = 16'h0;
   int          checks = 0, fails = 0, hp = 4, req_cnt = 0, err_cnt = 0;
   localparam logic [23:0] JID = 24'hEF4017;

   always #5 sys_clk = ~sys_clk;

   spi_flash_responder #(.ADDR_W(16), .JEDEC_ID(JID)) dut (
      .sys_clk    (sys_clk),
      .sys_reset  (sys_reset),
      .spi_cs_n   (spi_cs_n),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .spi_miso_oe(spi_miso_oe),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .cmd_err    (cmd_err)
   );

   // one-cycle-latency BRAM stand-in
   always @(posedge sys_clk) if (mem_req) mem_rdata <= mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle compare: every fetch must hit the next address in sequence, OE must stay low outside data phases
   always @(negedge sys_clk) begin
      if (!sys_reset) begin
         if (mem_req) begin
            chk("mem_req_allowed", 32'(req_ok), 32'd1);
            chk("mem_addr_seq", 32'(mem_addr), 32'(exp_addr));
            exp_addr = exp_addr + 16'd1;
            req_cnt++;
         end
         if (cmd_err) err_cnt++;
         if (no_oe) chk("oe_low", 32'(spi_miso_oe), 32'd0);
      end
   end

   function automatic logic [7:0] id_model(input int i);
      logic [23:0] v;
      v = JID >> (8 * (2 - i % 3));
      return v[7:0];
   endfunction

   task automatic spi_bit(input logic b, input logic open, output logic r);
      spi_mosi = b;
      repeat (hp) @(posedge sys_clk);
      #1;
      r = spi_miso;
      if (open) no_oe = 1'b0;
      spi_clk = 1'b1;
      repeat (hp) @(posedge sys_clk);
      #1;
      spi_clk = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] o, input logic open, output logic [7:0] i);
      logic r;
      for (int k = 7; k >= 0; k--) begin
         spi_bit(o[k], open && k == 0, r);
         i[k] = r;
      end
   endtask

   task automatic cs_start();
      @(posedge sys_clk);
      #1;
      spi_cs_n = 1'b0;
      repeat (4) @(posedge sys_clk);
   endtask

   task automatic cs_end();
      repeat (hp) @(posedge sys_clk);
      #1;
      spi_cs_n = 1'b1;
      repeat (8) @(posedge sys_clk);
      #1;
      no_oe  = 1'b1;
      req_ok = 1'b0;
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_oe", 32'(spi_miso_oe), 32'd0);
      chk("end_miso", 32'(spi_miso), 32'd0);
   endtask

   task automatic chk_reset_outs();
      chk("rst_miso", 32'(spi_miso), 32'd0);
      chk("rst_oe", 32'(spi_miso_oe), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(cmd_err), 32'd0);
   endtask

   task automatic send_head(input logic fast, input logic [23:0] a);
      logic [7:0] d;
      xfer(fast ? 8'h0B : 8'h03, 1'b0, d);
      exp_addr = a[15:0];
      req_ok   = 1'b1;
      xfer(a[23:16], 1'b0, d);
      xfer(a[15:8], 1'b0, d);
      xfer(a[7:0], !fast, d);
      if (fast) xfer(8'($urandom), 1'b1, d);
   endtask

   task automatic do_read(input logic fast, input logic [23:0] a, input int n);
      logic [7:0] d;
      int r0, e0;
      r0 = req_cnt;
      e0 = err_cnt;
      got.delete();
      cs_start();
      send_head(fast, a);
      for (int i = 0; i < n; i++) begin
         xfer(8'($urandom), 1'b0, d);
         got.push_back(d);
         chk(fast ? "fast_data" : "read_data", 32'(d), 32'(mem[16'(a + 24'(i))]));
      end
      cs_end();
      chk("read_req_count", 32'(req_cnt - r0), 32'(n + 1));
      chk("read_no_err", 32'(err_cnt - e0), 32'd0);
   endtask

   task automatic do_rdid(input int n);
      logic [7:0] d;
      got.delete();
      cs_start();
      xfer(8'h9F, 1'b1, d);
      for (int i = 0; i < n; i++) begin
         xfer(8'($urandom), 1'b0, d);
         got.push_back(d);
         chk("rdid_byte", 32'(d), 32'(id_model(i)));
      end
      cs_end();
   endtask

   task automatic do_bad(input logic [7:0] op, input int n);
      logic [7:0] d;
      int e0, r0;
      e0 = err_cnt;
      r0 = req_cnt;
      cs_start();
      xfer(op, 1'b0, d);
      for (int i = 0; i < n; i++) xfer(8'($urandom), 1'b0, d);
      chk("bad_err_pulses", 32'(err_cnt - e0), 32'd1);
      cs_end();
      chk("bad_no_req", 32'(req_cnt - r0), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  d;
      logic        r;
      logic [7:0]  lit_rd [4] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
      logic [7:0]  lit_id [6] = '{8'hEF, 8'h40, 8'h17, 8'hEF, 8'h40, 8'h17};
      logic [23:0] ra;
      logic [7:0]  op;
      int          r0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0010] = 8'hA5;
      mem[16'h0011] = 8'h5A;
      mem[16'h0012] = 8'h3C;
      mem[16'h0013] = 8'hC3;
      mem[16'hFFFF] = 8'h11;
      mem[16'h0000] = 8'h22;
      repeat (3) @(posedge sys_clk);
      #1;
      chk_reset_outs();
      sys_reset = 1'b0;
      repeat (6) @(posedge sys_clk);
      #1;
      chk_reset_outs();

      do_read(1'b0, 24'h000010, 4);
      for (int i = 0; i < 4; i++) chk("read_literal", 32'(got[i]), 32'(lit_rd[i]));

      do_read(1'b1, 24'h00FFFF, 2);
      chk("wrap_lit0", 32'(got[0]), 32'h11);
      chk("wrap_lit1", 32'(got[1]), 32'h22);

      do_rdid(6);
      for (int i = 0; i < 6; i++) chk("rdid_literal", 32'(got[i]), 32'(lit_id[i]));

      do_bad(8'h05, 2);
      do_read(1'b0, 24'h001234, 2);

      cs_start();
      xfer(8'h03, 1'b0, d);
      xfer(8'h00, 1'b0, d);
      for (int k = 0; k < 4; k++) spi_bit(1'b1, 1'b0, r);
      @(posedge sys_clk);
      #3;
      sys_reset = 1'b1;
      #1;
      chk_reset_outs();
      spi_clk  = 1'b0;
      spi_cs_n = 1'b1;
      req_ok   = 1'b0;
      no_oe    = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      sys_reset = 1'b0;
      repeat (4) @(posedge sys_clk);
      do_read(1'b0, 24'h000010, 2);
      chk("post_reset_lit", 32'(got[0]), 32'hA5);

      cs_start();
      send_head(1'b0, 24'h000040);
      for (int i = 0; i < 2; i++) begin
         xfer(8'h00, 1'b0, d);
         chk("abort_data", 32'(d), 32'(mem[16'h0040 + 16'(i)]));
      end
      for (int k = 0; k < 3; k++) spi_bit(1'b0, 1'b0, r);
      repeat (hp) @(posedge sys_clk);
      #1;
      req_ok   = 1'b0;
      r0       = req_cnt;
      spi_clk  = 1'b1;
      spi_cs_n = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_oe", 32'(spi_miso_oe), 32'd0);
      repeat (20) @(posedge sys_clk);
      #1;
      chk("abort_no_req", 32'(req_cnt - r0), 32'd0);
      spi_clk = 1'b0;
      no_oe   = 1'b1;
      repeat (4) @(posedge sys_clk);

      for (int t = 0; t < 12; t++) begin
         hp = $urandom_range(4, 6);
         ra = 24'($urandom);
         case ($urandom_range(0, 3))
            0: do_read(1'b0, ra, $urandom_range(1, 5));
            1: do_read(1'b1, ra, $urandom_range(1, 5));
            2: do_rdid($urandom_range(1, 7));
            default: begin
               op = 8'($urandom);
               while (op == 8'h03 || op == 8'h0B || op == 8'h9F) op = 8'($urandom);
               do_bad(op, $urandom_range(0, 2));
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
